// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the RV32M execute-stage multiply/divide
// sequencer: funct3 operation encoding, sequencer state encoding, the RV32
// corner-case constants, and small decode helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  // funct3 encoding of the RV32M operations.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4,
    S_DRAIN  = 3'd5
  } muldiv_state_e;

  // RV32 values of the most negative integer and of -1.
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic isDivOp(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as two's complement.
  function automatic logic isSignedA(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as two's complement.
  function automatic logic isSignedB(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  // The result comes from the low half ({hi, lo} -> lo, {rem, quo} -> quo).
  function automatic logic isLoHalf(input muldiv_op_e op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Purely combinational sign handling around the unsigned iterative unit.
//   Operand side : src_a/src_b + signed_a/signed_b -> mag_a/mag_b (unsigned
//                  magnitudes) and neg_a/neg_b (operand was negative).
//   Result side  : raw_res (unsigned {hi,lo} or {rem,quo}) + fix_is_div and the
//                  registered operand signs -> fix_res, the signed-corrected
//                  2*XLEN result in the same layout.
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              signed_a,
  input  logic              signed_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_a,
  output logic              neg_b,
  input  logic              fix_is_div,
  input  logic              fix_neg_a,
  input  logic              fix_neg_b,
  input  logic [2*XLEN-1:0] raw_res,
  output logic [2*XLEN-1:0] fix_res
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // NOTE: every output gets a value on every path through this block, so
  // no latch is inferred.
  always_comb begin
    neg_a = signed_a & src_a[XLEN-1];
    neg_b = signed_b & src_b[XLEN-1];
    // The most negative value negates to itself, which is also its correct
    // unsigned magnitude.
    mag_a = neg_a ? -src_a : src_a;
    mag_b = neg_b ? -src_b : src_b;

    quo = raw_res[XLEN-1:0];
    rem = raw_res[2*XLEN-1:XLEN];
    if (fix_is_div) begin
      // Quotient sign is the XOR of operand signs; remainder follows dividend.
      fix_res = {(fix_neg_a ? -rem : rem),
                 ((fix_neg_a ^ fix_neg_b) ? -quo : quo)};
    end else begin
      fix_res = (fix_neg_a ^ fix_neg_b) ? -raw_res : raw_res;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Execute-stage sequencer for the iterative RV32M multiply/divide unit.
// Decodes funct3, strips operand signs, launches the unit with a one-cycle
// start pulse, stalls the pipeline until the result is back, then corrects
// signs and selects the 32-bit rd value. Divide-by-zero and signed overflow
// are resolved locally without launching the unit.
//
// Ports
//   clk, rst_n              clock, async active-low reset (shared with unit)
//   isMulE, aluCtrlE[2:0]   M instruction valid in Execute, funct3
//   srcAE, srcBE            rs1 / rs2 values
//   flushE                  kill the Execute instruction
//   mulStallE               hold IF/ID/E
//   mulValidE, mulResultE   one-cycle result valid, rd value
//   unitStart, unitIsDiv    launch pulse, 0 = multiply / 1 = divide
//   unitA, unitB            unsigned operand magnitudes to the unit
//   unitDone, unitRes       unit completion pulse, {hi,lo} or {rem,quo}
//
// Build option
//   MULDIV_FUSE_EN  keep the last corrected result and reuse it for a
//                   matching follow-up operation (MUL after MULH*, DIV<->REM).
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isMulE,
  input  logic [3:0]        aluCtrlE,
  input  logic [XLEN-1:0]   srcAE,
  input  logic [XLEN-1:0]   srcBE,
  input  logic              flushE,
  output logic              mulStallE,
  output logic              mulValidE,
  output logic [XLEN-1:0]   mulResultE,
  output logic              unitStart,
  output logic              unitIsDiv,
  output logic [XLEN-1:0]   unitA,
  output logic [XLEN-1:0]   unitB,
  input  logic              unitDone,
  input  logic [2*XLEN-1:0] unitRes
);

  // Package constants are the RV32 values; other widths derive them directly.
  localparam logic [XLEN-1:0] INT_MIN_X  =
    (XLEN == 32) ? XLEN'(INT_MIN) : {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES_X =
    (XLEN == 32) ? XLEN'(ALL_ONES) : {XLEN{1'b1}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] raw_q, raw_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Bit 3 of the ALU control carries no meaning for M operations.
  logic unused_ctrl;
  assign unused_ctrl = aluCtrlE[3];

  muldiv_op_e        op_in;
  logic              is_div_in;
  logic              is_rem_in;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_a_in, neg_b_in;
  logic [2*XLEN-1:0] fixed;
  logic [XLEN-1:0]   fixed_sel;
  logic              fuse_hit;
  logic [XLEN-1:0]   fuse_res;

  assign op_in = muldiv_op_e'(aluCtrlE[2:0]);

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .src_a      (srcAE),
    .src_b      (srcBE),
    .signed_a   (isSignedA(op_in)),
    .signed_b   (isSignedB(op_in)),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_a      (neg_a_in),
    .neg_b      (neg_b_in),
    .fix_is_div (isDivOp(op_q)),
    .fix_neg_a  (neg_a_q),
    .fix_neg_b  (neg_b_q),
    .raw_res    (raw_q),
    .fix_res    (fixed)
  );

  // Divide corner cases that never reach the unit.
  always_comb begin
    is_div_in = isDivOp(op_in);
    is_rem_in = is_div_in & ~isLoHalf(op_in);
    div_zero  = is_div_in & (srcBE == '0);
    div_ovf   = is_div_in & isSignedA(op_in) &
                (srcAE == INT_MIN_X) & (srcBE == ALL_ONES_X);
    if (div_zero) begin
      special_res = is_rem_in ? srcAE : ALL_ONES_X;
    end else begin
      special_res = is_rem_in ? '0 : INT_MIN_X;
    end
    fixed_sel = isLoHalf(op_q) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_FUSE_EN
  // Last-result cache: raw operands, funct3 and the 64-bit corrected result.
  logic              fz_valid_q, fz_valid_d;
  logic [XLEN-1:0]   fz_a_q, fz_a_d;
  logic [XLEN-1:0]   fz_b_q, fz_b_d;
  muldiv_op_e        fz_op_q, fz_op_d;
  logic [2*XLEN-1:0] fz_res_q, fz_res_d;
  logic [XLEN-1:0]   src_a_q, src_a_d;
  logic [XLEN-1:0]   src_b_q, src_b_d;

  always_comb begin
    fuse_hit = 1'b0;
    if (fz_valid_q && (srcAE == fz_a_q) && (srcBE == fz_b_q)) begin
      unique case (op_in)
        // The low product word does not depend on operand signedness.
        OP_MUL:                       fuse_hit = !isDivOp(fz_op_q);
        OP_MULH, OP_MULHSU, OP_MULHU: fuse_hit = (fz_op_q == op_in);
        // DIV/REM share bit 0 = 0, DIVU/REMU share bit 0 = 1.
        default:                      fuse_hit = isDivOp(fz_op_q) &&
                                                 (fz_op_q[0] == op_in[0]);
      endcase
    end
    fuse_res = isLoHalf(op_in) ? fz_res_q[XLEN-1:0] : fz_res_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    fz_valid_d = fz_valid_q;
    fz_a_d     = fz_a_q;
    fz_b_d     = fz_b_q;
    fz_op_d    = fz_op_q;
    fz_res_d   = fz_res_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    if (state_q == S_IDLE && isMulE && !flushE) begin
      src_a_d = srcAE;
      src_b_d = srcBE;
    end
    // Every abort goes through flushE, so it alone invalidates the cache.
    if (flushE) begin
      fz_valid_d = 1'b0;
    end else if (state_q == S_FIX) begin
      fz_valid_d = 1'b1;
      fz_a_d     = src_a_q;
      fz_b_d     = src_b_q;
      fz_op_d    = op_q;
      fz_res_d   = fixed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fz_valid_q <= 1'b0;
      fz_a_q     <= '0;
      fz_b_q     <= '0;
      fz_op_q    <= OP_MUL;
      fz_res_q   <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
    end else begin
      fz_valid_q <= fz_valid_d;
      fz_a_q     <= fz_a_d;
      fz_b_q     <= fz_b_d;
      fz_op_q    <= fz_op_d;
      fz_res_q   <= fz_res_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
    end
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (isMulE && !flushE) begin
          op_d    = op_in;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          a_d     = mag_a;
          b_d     = mag_b;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else if (fuse_hit) begin
            result_d = fuse_res;
            state_d  = S_DONE;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      // The start pulse is issued in this cycle even when flushed, so a flush
      // still has to wait for the unit to finish.
      S_LAUNCH: state_d = flushE ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (unitDone) begin
          raw_d   = unitRes;
          // A flush coinciding with completion leaves nothing to drain.
          state_d = flushE ? S_IDLE : S_FIX;
        end else if (flushE) begin
          state_d = S_DRAIN;
        end
      end
      S_FIX: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          result_d = fixed_sel;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (unitDone) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      result_q <= result_d;
    end
  end

  // Outputs.
  always_comb begin
    unitStart  = (state_q == S_LAUNCH);
    mulValidE  = (state_q == S_DONE) && !flushE;
    mulStallE  = (isMulE && (state_q != S_DONE)) || (state_q == S_DRAIN);
    unitIsDiv  = isDivOp(op_q);
    unitA      = a_q;
    unitB      = b_q;
    mulResultE = result_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        isMulE = 1'b0;
  logic [3:0]  aluCtrlE = 4'h0;
  logic [31:0] srcAE = '0;
  logic [31:0] srcBE = '0;
  logic        flushE = 1'b0;
  logic        mulStallE, mulValidE, unitStart, unitIsDiv, unitDone;
  logic [31:0] mulResultE, unitA, unitB;
  logic [63:0] unitRes;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .isMulE     (isMulE),
    .aluCtrlE   (aluCtrlE),
    .srcAE      (srcAE),
    .srcBE      (srcBE),
    .flushE     (flushE),
    .mulStallE  (mulStallE),
    .mulValidE  (mulValidE),
    .mulResultE (mulResultE),
    .unitStart  (unitStart),
    .unitIsDiv  (unitIsDiv),
    .unitA      (unitA),
    .unitB      (unitB),
    .unitDone   (unitDone),
    .unitRes    (unitRes)
  );

  // Behavioural iterative unit: latency unit_lat cycles after the start pulse.
  int          unit_lat = 1;
  int          cnt = 0;
  int          start_total = 0;
  logic [63:0] unit_res_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 0;
      unit_res_r <= '0;
    end else if (unitStart) begin
      cnt         <= unit_lat;
      start_total <= start_total + 1;
      if (unitIsDiv)
        unit_res_r <= (unitB == 0) ? {unitA, 32'hFFFF_FFFF}
                                   : {unitA % unitB, unitA / unitB};
      else
        unit_res_r <= {32'h0, unitA} * {32'h0, unitB};
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end
  assign unitDone = (cnt == 1);
  assign unitRes  = unit_res_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_res;
    logic        launch;
    logic [31:0] exp_ua;
    logic [31:0] exp_ub;
  } vec_t;

  // Issues one instruction from IDLE and checks result, latency, stall,
  // launch count and the operands presented to the unit.
  task automatic run_op(input vec_t v);
    int          cyc = 0;
    int          vcyc = -1;
    int          s0;
    logic        stall_ok = 1'b1;
    logic [31:0] res = '0;
    logic [31:0] ua = '0;
    logic [31:0] ub = '0;
    logic        isdiv = 1'b0;
    s0 = start_total;
    @(posedge clk); #1;
    unit_lat = v.lat;
    isMulE   = 1'b1;
    aluCtrlE = {1'b0, v.f3};
    srcAE    = v.a;
    srcBE    = v.b;
    while (vcyc < 0 && cyc < 200) begin
      @(negedge clk);
      if (unitStart) begin
        ua = unitA; ub = unitB; isdiv = unitIsDiv;
      end
      if (mulValidE) begin
        vcyc = cyc;
        res  = mulResultE;
        if (mulStallE) stall_ok = 1'b0;
      end else if (!mulStallE) begin
        stall_ok = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    isMulE = 1'b0;
    check({v.name, "_valid_cycle"}, vcyc, v.launch ? v.lat + 3 : 1);
    check({v.name, "_result"}, res, v.exp_res);
    check({v.name, "_stall"}, stall_ok, 1'b1);
    check({v.name, "_starts"}, start_total - s0, v.launch ? 1 : 0);
    if (v.launch) begin
      check({v.name, "_unitA"}, ua, v.exp_ua);
      check({v.name, "_unitB"}, ub, v.exp_ub);
      check({v.name, "_unitIsDiv"}, isdiv, v.f3[2]);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int          nvalid;
    int          done_cyc;
    int          start_cyc;
    int          s0;
    logic [31:0] res;
    vec_t        v;

    vecs[0]  = '{"mulh_neg",   3'b001, 32'hFFFF_FFFE, 32'h3,         32, 32'hFFFF_FFFF, 1'b1, 32'h2,         32'h3};
    vecs[1]  = '{"div_zero",   3'b100, 32'h7,         32'h0,         3,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{"remu_zero",  3'b111, 32'h7,         32'h0,         3,  32'h7,         1'b0, 32'h0,         32'h0};
    vecs[3]  = '{"div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 3,  32'h8000_0000, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{"rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 3,  32'h0,         1'b0, 32'h0,         32'h0};
    vecs[5]  = '{"rem_neg",    3'b110, 32'hFFFF_FFF9, 32'h2,         4,  32'hFFFF_FFFF, 1'b1, 32'h7,         32'h2};
    vecs[6]  = '{"mul_small",  3'b000, 32'h3,         32'h4,         2,  32'hC,         1'b1, 32'h3,         32'h4};
    vecs[7]  = '{"mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8]  = '{"mulhsu_neg", 3'b010, 32'hFFFF_FFFF, 32'h2,         3,  32'hFFFF_FFFF, 1'b1, 32'h1,         32'h2};
    vecs[9]  = '{"div_neg",    3'b100, 32'hFFFF_FFEC, 32'h3,         5,  32'hFFFF_FFFA, 1'b1, 32'h14,        32'h3};
    vecs[10] = '{"divu_big",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 2,  32'h0,         1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[11] = '{"mul_intmin", 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 2,  32'h8000_0000, 1'b1, 32'h8000_0000, 32'h1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", mulStallE, 1'b0);
    check("rst_valid", mulValidE, 1'b0);
    check("rst_result", mulResultE, 32'h0);
    check("rst_start", unitStart, 1'b0);
    check("rst_isdiv", unitIsDiv, 1'b0);
    check("rst_unitA", unitA, 32'h0);
    check("rst_unitB", unitB, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);
    v = '{"div_pos_negb", 3'b100, 32'h7, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFD, 1'b1, 32'h7, 32'h2};
    run_op(v);

    // Flush in WAIT, then a new MUL while the old unit result drains.
    s0 = start_total;
    @(posedge clk); #1;
    unit_lat = 10; isMulE = 1'b1; aluCtrlE = 4'h0; srcAE = 32'h5; srcBE = 32'h6;
    @(posedge clk); #1;                       // LAUNCH
    @(posedge clk); #1; flushE = 1'b1;        // WAIT
    @(posedge clk); #1; flushE = 1'b0;        // DRAIN, new instruction
    unit_lat = 2; srcAE = 32'h3; srcBE = 32'h4;
    nvalid = 0; done_cyc = -1; start_cyc = -1; res = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("drain_stall", mulStallE, 1'b1);
      if (unitDone && done_cyc < 0) done_cyc = i;
      if (unitStart && start_cyc < 0) start_cyc = i;
      if (mulValidE) begin
        nvalid++;
        res = mulResultE;
      end
      @(posedge clk); #1;
      if (nvalid > 0) isMulE = 1'b0;
    end
    check("flush_valid_count", nvalid, 1);
    check("flush_result", res, 32'hC);
    check("flush_starts", start_total - s0, 2);
    check("flush_restart_after_drain", (done_cyc >= 0) && (start_cyc > done_cyc), 1'b1);

    // Reset in the middle of a long operation.
    @(posedge clk); #1;
    unit_lat = 20; isMulE = 1'b1; aluCtrlE = 4'h0; srcAE = 32'h9; srcBE = 32'h9;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; isMulE = 1'b0;
    @(negedge clk);
    check("midrst_result", mulResultE, 32'h0);
    check("midrst_unitA", unitA, 32'h0);
    check("midrst_stall", mulStallE, 1'b0);
    check("midrst_start", unitStart, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    v = '{"mul_after_rst", 3'b000, 32'h9, 32'h9, 2, 32'h51, 1'b1, 32'h9, 32'h9};
    run_op(v);

`ifdef MULDIV_FUSE_EN
    v = '{"fuse_mulhu", 3'b011, 32'h0001_0000, 32'h0001_0000, 3, 32'h1, 1'b1, 32'h0001_0000, 32'h0001_0000};
    run_op(v);
    v = '{"fuse_mul_hit", 3'b000, 32'h0001_0000, 32'h0001_0000, 3, 32'h0, 1'b0, 32'h0, 32'h0};
    run_op(v);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
